seq_symbol_feeder: RTL and testbench

Upstream stage of the MFA top module. Accepts a 2-bit-per-base sequence as packed words over a valid/ready interface, buffers them in a small word FIFO, and emits one 2-bit symbol per accepted handshake, LSB-first, to the matcher's symbol input. It knows the sequence length, requests exactly the words it needs, flags the final symbol, and pulses `done` on completion.

---
 rtl/mfa_pkg.sv | 13 +
 rtl/seq_symbol_feeder_if.sv | 25 ++
 rtl/sym_word_fifo.sv | 57 +++++
 rtl/seq_symbol_feeder.sv | 121 ++++++++++++
 tb/tb_seq_symbol_feeder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mfa_pkg.sv
// Shared types for the MFA datapath: symbol width, symbol type and the
// feeder control-state encoding.
package mfa_pkg;
    localparam int SYM_W = 2;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/seq_symbol_feeder_if.sv
// Word-in / symbol-out handshake bundle of the symbol feeder.
// master = the environment (word source, symbol sink); slave = the feeder.
interface seq_symbol_feeder_if #(
    parameter int WORD_W = 32
);
    import mfa_pkg::*;

    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    sym_t              symbol;
    logic              sym_valid;
    logic              sym_ready;
    logic              last;

    modport master (
        output word_data, word_valid, sym_ready,
        input  word_ready, symbol, sym_valid, last
    );

    modport slave (
        input  word_data, word_valid, sym_ready,
        output word_ready, symbol, sym_valid, last
    );
endinterface

// File: rtl/sym_word_fifo.sv
// Small synchronous word FIFO with registered full/empty and occupancy count.
// The head word is read straight from storage; there is no fall-through path.
module sym_word_fifo #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  logic [WORD_W-1:0]          push_data,
    input  logic                       pop,
    output logic [WORD_W-1:0]          head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage carries data only, so it is left out of reset
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/seq_symbol_feeder.sv
// Sequence feeder: buffers packed 2-bit-per-base words and emits one symbol per
// handshake, LSB-first, requesting exactly the words the sequence length needs.
module seq_symbol_feeder
    import mfa_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4,
    parameter int LEN_W  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [LEN_W-1:0]     seq_len,
    seq_symbol_feeder_if.slave   bus,
    output logic                 busy,
    output logic                 done
);
    localparam int SPW   = WORD_W / SYM_W;
    localparam int IDX_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int LW1   = LEN_W + 1;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   need_q, need_d;
    logic [LEN_W-1:0]   wacc_q, wacc_d;
    logic [LEN_W-1:0]   scnt_q, scnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [LW1-1:0]     len_round;
    logic [LEN_W-1:0]   need_calc;
    logic               run;
    logic               fifo_push, fifo_pop;
    logic [WORD_W-1:0]  fifo_head;
    logic               fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic               sym_hs, is_final, word_end;

    // one extra bit so that seq_len = 2^LEN_W-1 rounds up without wrapping
    assign len_round = {1'b0, seq_len} + LW1'(SPW - 1);
    assign need_calc = LEN_W'(len_round / LW1'(SPW));

    assign run      = (state_q == RUN);
    assign is_final = (scnt_q == (len_q - LEN_W'(1)));
    assign word_end = (idx_q == IDX_W'(SPW - 1));

    assign bus.word_ready = run && !fifo_full && (wacc_q < need_q);
    assign bus.sym_valid  = run && !fifo_empty;
    assign bus.symbol     = bus.sym_valid ? sym_t'(fifo_head[{idx_q, 1'b0} +: SYM_W]) : '0;
    assign bus.last       = bus.sym_valid && is_final;
    assign busy           = run;
    assign done           = (state_q == DONE);

    assign fifo_push = bus.word_valid && bus.word_ready;
    assign sym_hs    = bus.sym_valid && bus.sym_ready;
    // leftover upper symbols of the final word are dropped by popping early
    assign fifo_pop  = sym_hs && (word_end || is_final);

    sym_word_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (fifo_push),
        .push_data (bus.word_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        need_d  = need_q;
        wacc_d  = wacc_q;
        scnt_d  = scnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = seq_len;
                    need_d  = need_calc;
                    wacc_d  = '0;
                    scnt_d  = '0;
                    idx_d   = '0;
                    state_d = (seq_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fifo_push) wacc_d = wacc_q + LEN_W'(1);
                if (sym_hs) begin
                    scnt_d = scnt_q + LEN_W'(1);
                    idx_d  = fifo_pop ? '0 : idx_q + IDX_W'(1);
                    if (is_final) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            len_q   <= '0;
            need_q  <= '0;
            wacc_q  <= '0;
            scnt_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            need_q  <= need_d;
            wacc_q  <= wacc_d;
            scnt_q  <= scnt_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: tb/tb_seq_symbol_feeder.sv
// Bench for seq_symbol_feeder: directed sequences checked every cycle against a
// model that slices the offered words into the expected symbol stream.
module tb_seq_symbol_feeder;
    import mfa_pkg::*;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int LEN_W  = 16;
    localparam int SPW    = WORD_W / 2;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] seq_len = '0;
    logic             busy, done;

    seq_symbol_feeder_if #(.WORD_W(WORD_W)) bus ();

    seq_symbol_feeder #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .start   (start),
        .seq_len (seq_len),
        .bus     (bus),
        .busy    (busy),
        .done    (done)
    );

    always #5 CLK = ~CLK;

    int checks;
    int errors;

    // source / sink control
    logic [31:0] src_words [$];
    int          src_pos;
    int          rdy_mode;      // 0: always ready, 1: toggle, 2: never
    bit          word_taken;

    // model state
    int          m_phase;       // 0 idle, 1 run, 2 done
    int          m_len;
    int          m_sym_n;
    int          m_words_acc;
    int          m_cyc;
    int          m_done_lat;
    int          m_last_idx;
    bit          m_done_seen;
    logic [31:0] m_words [$];
    int          obs_syms [$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_sym(input int n);
        logic [31:0] w;
        if (n / SPW >= m_words.size()) return -1;
        w = m_words[n / SPW];
        return int'((w >> (2 * (n % SPW))) & 32'd3);
    endfunction

    function automatic int out_vec();
        return int'({bus.word_ready, bus.sym_valid, bus.symbol, bus.last, busy, done});
    endfunction

    task automatic begin_seq(input int len, input int mode);
        @(negedge CLK); #1;
        rdy_mode   = mode;
        src_pos    = 0;
        word_taken = 0;
        @(posedge CLK); #1;
        start   = 1'b1;
        seq_len = LEN_W'(len);
        @(posedge CLK); #1;
        start   = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input int extra_at);
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge CLK);
            if (m_done_seen) break;
            if (i == extra_at) begin
                #1; start = 1'b1; seq_len = LEN_W'(5);
            end else if (i == extra_at + 1) begin
                #1; start = 1'b0;
            end
        end
        if (!m_done_seen) check("done_timeout", 0, 1);
        repeat (2) @(posedge CLK);
    endtask

    initial begin
        checks = 0; errors = 0;
        src_pos = 0; rdy_mode = 0; word_taken = 0;
        m_phase = 0; m_len = 0; m_sym_n = 0; m_words_acc = 0;
        m_cyc = 0; m_done_lat = -1; m_last_idx = -1; m_done_seen = 0;
        bus.word_data = '0; bus.word_valid = 1'b0; bus.sym_ready = 1'b0;

        fork
            begin : monitor
                int nxt;
                int e;
                forever begin
                    @(negedge CLK);
                    if (!RST) begin
                        check("rst_outputs", out_vec(), 0);
                        m_phase = 0;
                        continue;
                    end
                    m_cyc++;
                    check("busy", int'(busy), int'(m_phase == 1));
                    check("done", int'(done), int'(m_phase == 2));
                    if (m_phase == 2) begin
                        m_done_seen = 1;
                        m_done_lat  = m_cyc;
                    end
                    if (!bus.sym_valid) check("sym_idle_zero", int'({bus.symbol, bus.last}), 0);
                    if (m_phase != 1) check("idle_no_handshake", int'({bus.word_ready, bus.sym_valid}), 0);
                    nxt = m_phase;
                    case (m_phase)
                        0: if (start) begin
                            m_len       = int'(seq_len);
                            m_words     = src_words;
                            m_sym_n     = 0;
                            m_words_acc = 0;
                            m_cyc       = 0;
                            m_last_idx  = -1;
                            m_done_seen = 0;
                            obs_syms.delete();
                            nxt = (seq_len == '0) ? 2 : 1;
                        end
                        1: begin
                            if (bus.word_valid && bus.word_ready) begin
                                word_taken = 1;
                                m_words_acc++;
                                check("word_within_need", int'(m_words_acc <= (m_len + SPW - 1) / SPW), 1);
                            end
                            if (bus.sym_valid) begin
                                if (m_sym_n >= m_len) begin
                                    check("extra_symbol", m_sym_n, m_len - 1);
                                end else begin
                                    e = exp_sym(m_sym_n);
                                    check("symbol", int'(bus.symbol), e);
                                    check("last", int'(bus.last), int'(m_sym_n == m_len - 1));
                                end
                                if (bus.sym_ready) begin
                                    obs_syms.push_back(int'(bus.symbol));
                                    if (bus.last) m_last_idx = m_sym_n;
                                    if (m_sym_n == m_len - 1) nxt = 2;
                                    m_sym_n++;
                                end
                            end
                        end
                        default: nxt = 0;
                    endcase
                    m_phase = nxt;
                end
            end
            begin : source
                forever begin
                    @(posedge CLK);
                    if (word_taken) begin
                        src_pos++;
                        word_taken = 0;
                    end
                    #1;
                    if (src_pos < src_words.size()) begin
                        bus.word_valid = 1'b1;
                        bus.word_data  = src_words[src_pos];
                    end else begin
                        bus.word_valid = 1'b0;
                        bus.word_data  = '0;
                    end
                    case (rdy_mode)
                        0:       bus.sym_ready = 1'b1;
                        1:       bus.sym_ready = ~bus.sym_ready;
                        default: bus.sym_ready = 1'b0;
                    endcase
                end
            end
        join_none

        #1 RST = 1'b0;
        #1 check("reset_outputs", out_vec(), 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;

        // basic stream: one word, 16 symbols 3,2,1,0 repeating
        src_words = '{32'h1B1B_1B1B};
        begin_seq(16, 0);
        wait_done(100, -1);
        check("basic_count", obs_syms.size(), 16);
        check("basic_sym0", obs_syms[0], 3);
        check("basic_sym1", obs_syms[1], 2);
        check("basic_sym2", obs_syms[2], 1);
        check("basic_sym3", obs_syms[3], 0);
        check("basic_last_idx", m_last_idx, 15);
        check("basic_done_lat", m_done_lat, 18);

        // partial final word; a third word is offered and must be refused
        src_words = '{32'hFFFF_FFFF, 32'h0000_0006, 32'hDEAD_BEEF};
        begin_seq(18, 0);
        wait_done(100, -1);
        check("partial_words", m_words_acc, 2);
        check("partial_src_pos", src_pos, 2);
        check("partial_sym17", obs_syms[16], 2);
        check("partial_sym18", obs_syms[17], 1);
        check("partial_last_idx", m_last_idx, 17);

        // sustained rate across word boundaries
        src_words = '{32'h0123_4567, 32'h89AB_CDEF, 32'hE4E4_E4E4};
        begin_seq(48, 0);
        wait_done(200, -1);
        check("stream_done_lat", m_done_lat, 50);
        check("stream_sym0", obs_syms[0], 3);
        check("stream_sym16", obs_syms[16], 3);

        // backpressure: sym_ready toggling, a fifth word offered
        src_words = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0, 32'hA5A5_5A5A, 32'h7777_7777};
        begin_seq(64, 1);
        wait_done(400, -1);
        check("bp_count", obs_syms.size(), 64);
        check("bp_words", m_words_acc, 4);

        // stalled sink: FIFO fills to DEPTH and the word side stops
        src_words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                      32'h5555_5555, 32'h6666_6666, 32'h7654_3210};
        begin_seq(100, 2);
        repeat (12) @(posedge CLK);
        check("full_words", m_words_acc, DEPTH);
        check("full_no_symbols", obs_syms.size(), 0);
        rdy_mode = 0;
        wait_done(400, -1);
        check("full_count", obs_syms.size(), 100);
        check("full_words_total", m_words_acc, 7);

        // start while busy is ignored
        src_words = '{32'hCAFE_F00D, 32'h0000_0009};
        begin_seq(20, 0);
        wait_done(100, 5);
        check("busy_start_count", obs_syms.size(), 20);
        check("busy_start_last", m_last_idx, 19);
        check("busy_start_lat", m_done_lat, 22);

        // reset mid-stream with three words buffered
        src_words = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
        begin_seq(64, 2);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            if (m_words_acc == 3) break;
        end
        check("rst_buffered", m_words_acc, 3);
        @(posedge CLK); #3;
        RST = 1'b0;
        #1 check("rst_async_outputs", out_vec(), 0);
        repeat (2) @(negedge CLK);
        @(posedge CLK); #2;
        RST = 1'b1;
        rdy_mode = 0;
        src_pos  = 0;
        repeat (8) @(posedge CLK);
        check("rst_stays_idle", int'(busy), 0);

        // zero length after reset
        src_words = '{32'h1B1B_1B1B};
        begin_seq(0, 0);
        wait_done(20, -1);
        check("zero_done_lat", m_done_lat, 1);
        check("zero_words", m_words_acc, 0);
        check("zero_symbols", obs_syms.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
